// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target for the j1 SoC. SCK, SS_n and MOSI are
// oversampled in the clk domain; received bytes go into a small RX FIFO and
// CPU-supplied bytes are returned on MISO, MSB first.
module spi_target #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  IDLE_BYTE  = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       ss_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic       wr,
    input  logic [7:0] tx_data,
    input  logic       rd,
    output logic [7:0] rx_data,
    output logic       valid,
    output logic       tx_pending,
    output logic       overrun,
    output logic       underrun,
    input  logic       clr_err,
    output logic       selected
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t      state, state_nx;

    // [1] is the synchronized value, [2] the previous one for edge detection
    logic [2:0]  sck_q;
    logic [2:0]  ss_q;
    logic [1:0]  mosi_q;

    logic [2:0]  bit_cnt;
    logic [6:0]  rx_shift;
    logic [7:0]  shifter;
    logic [7:0]  hold;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;

    logic        sck_rise, sck_fall, ss_fall, ss_rise, mosi_s;
    logic        do_load, do_shift, do_sample;
    logic        push, pop, push_ok, push_drop, empty, full;
    logic [7:0]  push_data;

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign ss_fall  = ~ss_q[1] & ss_q[2];
    assign ss_rise  = ss_q[1] & ~ss_q[2];
    assign mosi_s   = mosi_q[1];

    // Synchronize the asynchronous host pins and keep one stage of history.
    always_ff @(posedge clk) begin
        // NOTE: every sequential assignment is non-blocking so all flops see
        // the pre-edge values, which is what a shift chain depends on.
        if (reset) begin
            sck_q  <= 3'b000;
            ss_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sck_q  <= {sck_q[1:0], sck};
            ss_q   <= {ss_q[1:0], ss_n};
            mosi_q <= {mosi_q[0], mosi};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state and datapath strobes from the detected pin edges.
    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a signal
        // unassigned and infers a latch.
        state_nx  = state;
        do_load   = 1'b0;
        do_shift  = 1'b0;
        do_sample = 1'b0;
        unique case (state)
            IDLE: begin
                if (ss_fall) begin
                    do_load  = 1'b1;
                    state_nx = ACTIVE;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_nx = IDLE;
                end else begin
                    do_sample = sck_rise;
                    if (sck_fall) begin
                        // bit_cnt==0 here means a full byte was just shifted
                        do_load  = (bit_cnt == 3'd0);
                        do_shift = (bit_cnt != 3'd0);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign miso_oe  = (state == ACTIVE);
    assign miso     = (state == ACTIVE) & shifter[7];
    assign selected = ~ss_q[1];

    // Byte boundary: the 8th sampled bit completes the byte.
    assign push      = do_sample & (bit_cnt == 3'd7);
    assign push_data = {rx_shift, mosi_s};

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = rd & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok   = push & (~full | pop);
    assign push_drop = push & full & ~pop;

    assign valid     = ~empty;
    assign rx_data   = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    // Receive shifter, bit counter, transmit shifter and TX holding register.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= 3'd0;
            rx_shift   <= 7'd0;
            shifter    <= 8'd0;
            hold       <= 8'd0;
            tx_pending <= 1'b0;
        end else begin
            if (state_nx == IDLE)  bit_cnt <= 3'd0;
            else if (do_sample)    bit_cnt <= bit_cnt + 3'd1;

            if (do_sample) rx_shift <= {rx_shift[5:0], mosi_s};

            if (do_load)       shifter <= tx_pending ? hold : IDLE_BYTE;
            else if (do_shift) shifter <= {shifter[6:0], 1'b0};

            // A load takes the old held byte; a simultaneous wr stays pending.
            if (wr)           hold <= tx_data;
            if (wr)           tx_pending <= 1'b1;
            else if (do_load) tx_pending <= 1'b0;
        end
    end

    // Sticky error flags; a new error outranks clr_err in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (push_drop)    overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;

            if (do_load && !tx_pending) underrun <= 1'b1;
            else if (clr_err)           underrun <= 1'b0;
        end
    end

    // RX FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // RX FIFO storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers define which entries are
        // meaningful and rx_data is forced to 0 while empty.
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed and randomized SPI host transfers against a
// transaction-level model of the RX FIFO, TX holding register and flags.
module tb_spi_target;

    localparam int         DEPTH = 4;
    localparam logic [7:0] IDLE  = 8'hFF;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sck = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso, miso_oe, valid, tx_pending, overrun, underrun, selected;
    logic [7:0] rx_data;

    spi_target #(.FIFO_DEPTH(DEPTH), .IDLE_BYTE(IDLE)) dut (
        .clk        (clk),
        .reset      (reset),
        .sck        (sck),
        .ss_n       (ss_n),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .wr         (wr),
        .tx_data    (tx_data),
        .rd         (rd),
        .rx_data    (rx_data),
        .valid      (valid),
        .tx_pending (tx_pending),
        .overrun    (overrun),
        .underrun   (underrun),
        .clr_err    (clr_err),
        .selected   (selected)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: byte queue plus holding register and flags.
    logic [7:0] m_q[$];
    logic [7:0] m_hold = 8'h00;
    bit         m_pend = 1'b0;
    bit         m_over = 1'b0;
    bit         m_under = 1'b0;

    // Host-side transfer description.
    logic [7:0] h_out[8];
    bit         h_wr_en[8];
    logic [7:0] h_wr_val[8];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_load();
        if (m_pend) begin
            m_pend = 1'b0;
            return m_hold;
        end
        m_under = 1'b1;
        return IDLE;
    endfunction

    function automatic void m_push(input logic [7:0] b);
        if (m_q.size() < DEPTH) m_q.push_back(b);
        else                    m_over = 1'b1;
    endfunction

    function automatic void m_reset();
        m_q.delete();
        m_hold  = 8'h00;
        m_pend  = 1'b0;
        m_over  = 1'b0;
        m_under = 1'b0;
    endfunction

    function automatic logic [7:0] m_head();
        return (m_q.size() > 0) ? m_q[0] : 8'h00;
    endfunction

    task automatic check_status(input string tag);
        check({tag, ".valid"},      {7'd0, valid},      {7'd0, m_q.size() > 0});
        check({tag, ".rx_data"},    rx_data,            m_head());
        check({tag, ".tx_pending"}, {7'd0, tx_pending}, {7'd0, m_pend});
        check({tag, ".overrun"},    {7'd0, overrun},    {7'd0, m_over});
        check({tag, ".underrun"},   {7'd0, underrun},   {7'd0, m_under});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".miso"},       {7'd0, miso},       8'h00);
        check({tag, ".miso_oe"},    {7'd0, miso_oe},    8'h00);
        check({tag, ".valid"},      {7'd0, valid},      8'h00);
        check({tag, ".rx_data"},    rx_data,            8'h00);
        check({tag, ".tx_pending"}, {7'd0, tx_pending}, 8'h00);
        check({tag, ".overrun"},    {7'd0, overrun},    8'h00);
        check({tag, ".underrun"},   {7'd0, underrun},   8'h00);
        check({tag, ".selected"},   {7'd0, selected},   8'h00);
    endtask

    task automatic cpu_wr(input logic [7:0] v);
        @(negedge clk);
        wr = 1'b1;
        tx_data = v;
        @(negedge clk);
        wr = 1'b0;
        m_hold = v;
        m_pend = 1'b1;
    endtask

    task automatic cpu_rd(input string tag);
        @(negedge clk);
        check({tag, ".rd_valid"}, {7'd0, valid}, {7'd0, m_q.size() > 0});
        check({tag, ".rd_data"},  rx_data,       m_head());
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        if (m_q.size() > 0) void'(m_q.pop_front());
    endtask

    task automatic drain(input string tag);
        while (m_q.size() > 0) cpu_rd(tag);
        @(negedge clk);
        check_status({tag, ".empty"});
    endtask

    task automatic clear_errors();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_over  = 1'b0;
        m_under = 1'b0;
    endtask

    task automatic clear_wr_plan();
        for (int i = 0; i < 8; i++) begin
            h_wr_en[i]  = 1'b0;
            h_wr_val[i] = 8'h00;
        end
    endtask

    // One selection: nbytes bytes; the last one truncated to last_bits if >0.
    task automatic spi_xfer(input int nbytes, input int last_bits);
        logic [7:0] exp_in;
        logic [7:0] got;
        int         bits;
        @(negedge clk);
        ss_n = 1'b0;
        exp_in = m_load();
        repeat (5) @(negedge clk);
        check("miso_oe_selected", {7'd0, miso_oe}, 8'h01);
        for (int k = 0; k < nbytes; k++) begin
            bits = (k == nbytes - 1 && last_bits > 0) ? last_bits : 8;
            got = 8'h00;
            for (int b = 0; b < bits; b++) begin
                mosi = h_out[k][7-b];
                if (b == 3 && h_wr_en[k]) cpu_wr(h_wr_val[k]);
                repeat (5) @(negedge clk);
                if (b == 0) check("tx_pending_after_load", {7'd0, tx_pending}, {7'd0, m_pend});
                if (b == 7) check("underrun_in_byte", {7'd0, underrun}, {7'd0, m_under});
                got = {got[6:0], miso};
                sck = 1'b1;
                repeat (5) @(negedge clk);
                sck = 1'b0;
            end
            if (bits == 8) begin
                check("host_rx", got, exp_in);
                m_push(h_out[k]);
                exp_in = m_load();
            end
        end
        repeat (5) @(negedge clk);
        ss_n = 1'b1;
        repeat (6) @(negedge clk);
        check("miso_oe_deselected", {7'd0, miso_oe}, 8'h00);
    endtask

    initial begin
        clear_wr_plan();

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);

        // Single byte, nothing pending: host gets IDLE_BYTE, underrun set
        h_out[0] = 8'hA5;
        spi_xfer(1, 0);
        check_status("single");
        drain("single");
        clear_errors();
        check_status("after_clr");

        // Byte pending before select
        cpu_wr(8'h3C);
        check("pending_before_sel", {7'd0, tx_pending}, 8'h01);
        h_out[0] = 8'h00;
        spi_xfer(1, 0);
        drain("preload");
        clear_errors();

        // Five bytes into a four-deep FIFO
        for (int i = 0; i < 5; i++) h_out[i] = 8'(i + 1);
        spi_xfer(5, 0);
        check_status("overrun");
        drain("overrun");
        clear_errors();

        // Partial byte discarded, then a full byte
        h_out[0] = 8'($urandom);
        spi_xfer(1, 5);
        check_status("partial");
        h_out[0] = 8'h81;
        spi_xfer(1, 0);
        check_status("after_partial");
        drain("after_partial");
        clear_errors();

        // Back-to-back bytes with a wr during each byte
        cpu_wr(8'h11);
        h_out[0] = 8'($urandom);
        h_out[1] = 8'($urandom);
        h_wr_en[0] = 1'b1;
        h_wr_val[0] = 8'h22;
        spi_xfer(2, 0);
        check_status("b2b");
        drain("b2b");
        clear_errors();
        clear_wr_plan();

        // Randomized selections
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) cpu_wr(8'($urandom));
            for (int k = 0; k < n; k++) begin
                h_out[k]    = 8'($urandom);
                h_wr_en[k]  = 1'($urandom_range(0, 1));
                h_wr_val[k] = 8'($urandom);
            end
            spi_xfer(n, 0);
            check_status("rand");
            drain("rand");
            clear_errors();
            clear_wr_plan();
        end

        // Reset in the middle of a byte, with FIFO and TX register occupied
        h_out[0] = 8'hC3;
        spi_xfer(1, 0);
        @(negedge clk);
        ss_n = 1'b0;
        repeat (5) @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            mosi = 1'(b);
            sck = 1'b1;
            repeat (5) @(negedge clk);
            sck = 1'b0;
            repeat (5) @(negedge clk);
        end
        cpu_wr(8'h77);
        @(negedge clk);
        reset = 1'b1;
        ss_n = 1'b1;
        sck = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_reset();
        repeat (4) @(negedge clk);
        h_out[0] = 8'h5A;
        spi_xfer(1, 0);
        check_status("post_reset");
        drain("post_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
